// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: coprocessor-0 register file and exception commit unit.
// Prioritises pipeline exceptions, updates EPC/Cause/Status/BadVAddr, redirects
// fetch on exceptions and eret, serves mfc0/mtc0, and owns the Count/Compare timer.
// Optional feature macro: CP0_TIMER_EN (Count/Compare timer; absent -> timer regs read 0).
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic [31:0] pc,
    input  logic        in_delay,
    input  logic        adei,
    input  logic        ri,
    input  logic        ov,
    input  logic        sys,
    input  logic        bp,
    input  logic        adel,
    input  logic        ades,
    input  logic [31:0] bad_vaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [4:0]  raddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        exc_valid,
    output logic [31:0] exc_target,
    output logic        redirect
);

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    if (COUNT_DIV < 1) begin : g_div_check
        $error("cp0_exc_unit: COUNT_DIV must be >= 1");
    end

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    exc_code_e   exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        timer_irq;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;
    logic        int_pend;
    logic        exc_any;
    logic        mtc0_ok;
    exc_code_e   exc_code;
    logic        load_bva;

    assign int_pend  = ie_q & ~exl_q & |({ip_hw_q, ip_sw_q} & im_q);
    assign exc_any   = int_pend | adei | ri | ov | sys | bp | adel | ades;
    assign exc_valid = commit & exc_any;
    assign redirect  = exc_valid | (commit & eret & ~exc_any);
    assign exc_target = exc_valid ? EXC_VECTOR : epc_q;
    // mtc0 only lands when the writing instruction itself does not fault
    assign mtc0_ok   = commit & we & ~exc_any;

    // Priority encoder: pick the ExcCode and whether BadVAddr is captured
    always_comb begin
        exc_code = EXC_INT;
        load_bva = 1'b0;
        if (int_pend) begin
            exc_code = EXC_INT;
        end else if (adei) begin
            exc_code = EXC_ADEL;
            load_bva = 1'b1;
        end else if (ri) begin
            exc_code = EXC_RI;
        end else if (ov) begin
            exc_code = EXC_OV;
        end else if (sys) begin
            exc_code = EXC_SYS;
        end else if (bp) begin
            exc_code = EXC_BP;
        end else if (adel) begin
            exc_code = EXC_ADEL;
            load_bva = 1'b1;
        end else if (ades) begin
            exc_code = EXC_ADES;
            load_bva = 1'b1;
        end
    end

    // Next-state for Status/Cause/EPC/BadVAddr: exception, else mtc0 then eret
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_hw_d    = {timer_irq | hw_int[5], hw_int[4:0]};
        if (exc_valid) begin
            if (!exl_q) begin
                epc_d = in_delay ? pc - 32'd4 : pc;
                bd_d  = in_delay;
            end
            exl_d     = 1'b1;
            exccode_d = exc_code;
            if (load_bva) begin
                badvaddr_d = bad_vaddr;
            end
        end else if (commit) begin
            if (mtc0_ok) begin
                case (waddr)
                    5'd12: begin
                        im_d  = wdata[15:8];
                        exl_d = wdata[1];
                        ie_d  = wdata[0];
                    end
                    5'd13:   ip_sw_d = wdata[9:8];
                    5'd14:   epc_d   = wdata;
                    default: ;
                endcase
            end
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    // Register update for Status/Cause/EPC/BadVAddr
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= EXC_INT;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

`ifdef CP0_TIMER_EN
    localparam logic [31:0] DIV_LAST = 32'(COUNT_DIV - 1);

    logic [31:0] div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_irq_q, timer_irq_d;
    logic        tick;

    assign tick       = (div_q == DIV_LAST);
    assign timer_irq  = timer_irq_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;

    // Timer next-state: mtc0 Count beats the tick, mtc0 Compare beats the match
    always_comb begin
        div_d       = tick ? '0 : div_q + 32'd1;
        count_d     = tick ? count_q + 32'd1 : count_q;
        compare_d   = compare_q;
        timer_irq_d = timer_irq_q;
        if (mtc0_ok && waddr == 5'd9) begin
            count_d = wdata;
        end
        if (count_q == compare_q) begin
            timer_irq_d = 1'b1;
        end
        if (mtc0_ok && waddr == 5'd11) begin
            compare_d   = wdata;
            timer_irq_d = 1'b0;
        end
    end

    // Timer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            timer_irq_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_irq_q <= timer_irq_d;
        end
    end
`else
    assign timer_irq  = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    // mfc0 read mux; no bypass, so a same-cycle mtc0 shows the old value
    always_comb begin
        rdata = '0;
        case (raddr)
            5'd8:    rdata = badvaddr_q;
            5'd9:    rdata = count_rd;
            5'd11:   rdata = compare_rd;
            5'd12:   rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
            5'd13:   rdata = {bd_q, timer_irq, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
            5'd14:   rdata = epc_q;
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed self-checking bench for cp0_exc_unit.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit;
    logic [31:0] pc;
    logic        in_delay;
    logic        adei, ri, ov, sys, bp, adel, ades;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  waddr;
    logic [4:0]  raddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        redirect;

    int checks   = 0;
    int failures = 0;
    logic [31:0] v;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    cp0_exc_unit #(.EXC_VECTOR(VEC), .COUNT_DIV(2)) dut (
        .clk(clk), .reset(reset), .commit(commit), .pc(pc), .in_delay(in_delay),
        .adei(adei), .ri(ri), .ov(ov), .sys(sys), .bp(bp), .adel(adel), .ades(ades),
        .bad_vaddr(bad_vaddr), .eret(eret), .hw_int(hw_int), .we(we), .waddr(waddr),
        .raddr(raddr), .wdata(wdata), .rdata(rdata), .exc_valid(exc_valid),
        .exc_target(exc_target), .redirect(redirect)
    );

    always #5 clk = ~clk;

    task automatic clr();
        commit = 0; pc = '0; in_delay = 0; adei = 0; ri = 0; ov = 0; sys = 0;
        bp = 0; adel = 0; ades = 0; bad_vaddr = '0; eret = 0; we = 0;
        waddr = '0; wdata = '0;
    endtask

    // Advance one clock edge, then drop the per-instruction inputs
    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        raddr = a;
        #1;
        d = rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        commit = 1; we = 1; waddr = a; wdata = d;
        step();
    endtask

    task automatic test_reset();
        reset = 1; hw_int = '0; raddr = '0; clr();
        repeat (2) @(posedge clk);
        #1;
        rd(5'd12, v);
        checks++; if (v !== 32'h0040_0000) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h0040_0000); end
        rd(5'd13, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=%h", v, 32'h0); end
        rd(5'd14, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=%h", v, 32'h0); end
        checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL reset_exc_valid got=%b exp=0", exc_valid); end
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
        reset = 0;
    endtask

    task automatic test_mtc0();
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, v);
        checks++; if (v !== 32'h0040_FF03) begin failures++; $display("FAIL mtc0_status_mask got=%h exp=%h", v, 32'h0040_FF03); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v);
        checks++; if ({v[31], v[9:8], v[6:2]} !== 8'b0_11_00000) begin failures++; $display("FAIL mtc0_cause_mask got=%h exp_bits31,9:8,6:2=0_11_00000", v); end
        mtc0(5'd8, 32'hFFFF_FFFF);
        rd(5'd8, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL mtc0_badvaddr_ro got=%h exp=%h", v, 32'h0); end
        // Read-after-write in the same cycle returns the old EPC
        commit = 1; we = 1; waddr = 5'd14; wdata = 32'h1234_5678; raddr = 5'd14;
        #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL raw_old_epc got=%h exp=%h", rdata, 32'h0); end
        step();
        rd(5'd14, v);
        checks++; if (v !== 32'h1234_5678) begin failures++; $display("FAIL mtc0_epc got=%h exp=%h", v, 32'h1234_5678); end
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0);
        rd(5'd12, v);
        checks++; if (v !== 32'h0040_0000) begin failures++; $display("FAIL mtc0_status_clear got=%h exp=%h", v, 32'h0040_0000); end
    endtask

    task automatic test_adel();
        commit = 1; pc = 32'hBFC0_0100; adel = 1; bad_vaddr = 32'h0000_0003;
        #1;
        checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL adel_exc_valid got=%b exp=1", exc_valid); end
        checks++; if (exc_target !== VEC) begin failures++; $display("FAIL adel_target got=%h exp=%h", exc_target, VEC); end
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL adel_redirect got=%b exp=1", redirect); end
        step();
        rd(5'd14, v);
        checks++; if (v !== 32'hBFC0_0100) begin failures++; $display("FAIL adel_epc got=%h exp=%h", v, 32'hBFC0_0100); end
        rd(5'd13, v);
        checks++; if (v[6:2] !== 5'd4) begin failures++; $display("FAIL adel_code got=%0d exp=4", v[6:2]); end
        rd(5'd8, v);
        checks++; if (v !== 32'h3) begin failures++; $display("FAIL adel_badvaddr got=%h exp=%h", v, 32'h3); end
        rd(5'd12, v);
        checks++; if (v[1] !== 1'b1) begin failures++; $display("FAIL adel_exl got=%b exp=1", v[1]); end
    endtask

    task automatic test_ades_delay();
        mtc0(5'd12, 32'h0);
        commit = 1; pc = 32'hBFC0_0208; in_delay = 1; ades = 1; bad_vaddr = 32'h0000_1001;
        step();
        rd(5'd14, v);
        checks++; if (v !== 32'hBFC0_0204) begin failures++; $display("FAIL ades_epc got=%h exp=%h", v, 32'hBFC0_0204); end
        rd(5'd13, v);
        checks++; if (v[31] !== 1'b1) begin failures++; $display("FAIL ades_bd got=%b exp=1", v[31]); end
        checks++; if (v[6:2] !== 5'd5) begin failures++; $display("FAIL ades_code got=%0d exp=5", v[6:2]); end
        rd(5'd8, v);
        checks++; if (v !== 32'h0000_1001) begin failures++; $display("FAIL ades_badvaddr got=%h exp=%h", v, 32'h0000_1001); end
    endtask

    task automatic test_priority_eret();
        mtc0(5'd12, 32'h0);
        commit = 1; pc = 32'hBFC0_0300; ri = 1; sys = 1; adel = 1; bad_vaddr = 32'hDEAD_0000;
        step();
        rd(5'd13, v);
        checks++; if (v[6:2] !== 5'd10) begin failures++; $display("FAIL ri_code got=%0d exp=10", v[6:2]); end
        checks++; if (v[31] !== 1'b0) begin failures++; $display("FAIL ri_bd got=%b exp=0", v[31]); end
        rd(5'd8, v);
        checks++; if (v !== 32'h0000_1001) begin failures++; $display("FAIL ri_badvaddr_kept got=%h exp=%h", v, 32'h0000_1001); end
        commit = 1; eret = 1;
        #1;
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL eret_redirect got=%b exp=1", redirect); end
        checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL eret_exc_valid got=%b exp=0", exc_valid); end
        checks++; if (exc_target !== 32'hBFC0_0300) begin failures++; $display("FAIL eret_target got=%h exp=%h", exc_target, 32'hBFC0_0300); end
        step();
        rd(5'd12, v);
        checks++; if (v[1] !== 1'b0) begin failures++; $display("FAIL eret_exl got=%b exp=0", v[1]); end
    endtask

    task automatic test_priority_table();
        // {adei, ri, ov, sys, bp, adel, ades}, expected code, BadVAddr captured
        logic [6:0] flags [6] = '{7'b1100001, 7'b0011100, 7'b0001110, 7'b0000101, 7'b0000011, 7'b0000001};
        logic [4:0] codes [6] = '{5'd4, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
        logic       upd   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_bva = 32'h0000_1001;
        for (int i = 0; i < 6; i++) begin
            commit = 1; pc = 32'h8000_0000 + 32'(i * 4);
            {adei, ri, ov, sys, bp, adel, ades} = flags[i];
            bad_vaddr = 32'hA000_0000 + 32'(i);
            if (upd[i]) exp_bva = 32'hA000_0000 + 32'(i);
            #1;
            checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL prio_valid[%0d] got=%b exp=1", i, exc_valid); end
            step();
            rd(5'd13, v);
            checks++; if (v[6:2] !== codes[i]) begin failures++; $display("FAIL prio_code[%0d] got=%0d exp=%0d", i, v[6:2], codes[i]); end
            rd(5'd8, v);
            checks++; if (v !== exp_bva) begin failures++; $display("FAIL prio_bva[%0d] got=%h exp=%h", i, v, exp_bva); end
        end
    endtask

    task automatic test_exl_nested();
        mtc0(5'd12, 32'h0);
        commit = 1; pc = 32'h0000_00A0; adel = 1; bad_vaddr = 32'h0000_0100;
        step();
        // Second fault while EXL=1, carrying an mtc0 EPC that must be suppressed
        commit = 1; pc = 32'h0000_00B0; adel = 1; bad_vaddr = 32'h0000_0200;
        we = 1; waddr = 5'd14; wdata = 32'h1234_5678;
        step();
        rd(5'd14, v);
        checks++; if (v !== 32'h0000_00A0) begin failures++; $display("FAIL nested_epc got=%h exp=%h", v, 32'h0000_00A0); end
        rd(5'd8, v);
        checks++; if (v !== 32'h0000_0200) begin failures++; $display("FAIL nested_bva got=%h exp=%h", v, 32'h0000_0200); end
        rd(5'd13, v);
        checks++; if (v[6:2] !== 5'd4) begin failures++; $display("FAIL nested_code got=%0d exp=4", v[6:2]); end
    endtask

    task automatic test_hw_int();
        mtc0(5'd12, 32'h0000_8001);
        hw_int = 6'b100000;
        step();
        checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL int_no_commit got=%b exp=0", exc_valid); end
        commit = 1; pc = 32'h0000_4000;
        #1;
        checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL int_valid got=%b exp=1", exc_valid); end
        step();
        rd(5'd13, v);
        checks++; if (v[6:2] !== 5'd0) begin failures++; $display("FAIL int_code got=%0d exp=0", v[6:2]); end
        checks++; if (v[15] !== 1'b1) begin failures++; $display("FAIL int_ip7 got=%b exp=1", v[15]); end
        rd(5'd14, v);
        checks++; if (v !== 32'h0000_4000) begin failures++; $display("FAIL int_epc got=%h exp=%h", v, 32'h0000_4000); end
        commit = 1;
        #1;
        checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL int_masked_exl got=%b exp=0", exc_valid); end
        step();
        hw_int = '0;
        mtc0(5'd12, 32'h0);
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        int waited;
        mtc0(5'd9, 32'h0000_1000);
        rd(5'd9, v);
        checks++; if (v !== 32'h0000_1000) begin failures++; $display("FAIL count_write got=%h exp=%h", v, 32'h0000_1000); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        step(); step();
        rd(5'd9, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL count_wrap got=%h exp=%h", v, 32'h0); end
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        mtc0(5'd12, 32'h0000_8001);
        repeat (16) step();
        rd(5'd13, v);
        checks++; if (v[30] !== 1'b0) begin failures++; $display("FAIL ti_early got=%b exp=0", v[30]); end
        waited = 0;
        while (v[30] !== 1'b1 && waited < 6) begin
            step(); waited++;
            rd(5'd13, v);
        end
        checks++; if (v[30] !== 1'b1) begin failures++; $display("FAIL ti_timeout got=%b exp=1", v[30]); end
        step();
        commit = 1; pc = 32'h0000_5000;
        #1;
        checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL timer_int_valid got=%b exp=1", exc_valid); end
        step();
        rd(5'd13, v);
        checks++; if (v[6:2] !== 5'd0) begin failures++; $display("FAIL timer_int_code got=%0d exp=0", v[6:2]); end
        mtc0(5'd11, 32'hFFFF_0000);
        rd(5'd13, v);
        checks++; if (v[30] !== 1'b0) begin failures++; $display("FAIL ti_clear got=%b exp=0", v[30]); end
        mtc0(5'd12, 32'h0);
    endtask
`else
    task automatic test_timer();
        mtc0(5'd9, 32'h0000_0005);
        mtc0(5'd11, 32'h0000_0007);
        step();
        rd(5'd9, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL count_disabled got=%h exp=%h", v, 32'h0); end
        rd(5'd11, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL compare_disabled got=%h exp=%h", v, 32'h0); end
        rd(5'd13, v);
        checks++; if (v[30] !== 1'b0) begin failures++; $display("FAIL ti_disabled got=%b exp=0", v[30]); end
    endtask
`endif

    task automatic test_reset_mid_exc();
        mtc0(5'd12, 32'h0);
        reset = 1; commit = 1; pc = 32'h0000_7000; adel = 1; bad_vaddr = 32'h0000_0077;
        step();
        reset = 0;
        rd(5'd14, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_mid_epc got=%h exp=%h", v, 32'h0); end
        rd(5'd12, v);
        checks++; if (v !== 32'h0040_0000) begin failures++; $display("FAIL rst_mid_status got=%h exp=%h", v, 32'h0040_0000); end
        rd(5'd8, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_mid_bva got=%h exp=%h", v, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_mtc0();
        test_adel();
        test_ades_delay();
        test_priority_eret();
        test_priority_table();
        test_exl_nested();
        test_hw_int();
        test_timer();
        test_reset_mid_exc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
